mesh_out_arbiter: RTL and testbench

Round-robin output-port arbiter for one mesh router terminal. It shares a single output link between `N_IN` input FIFOs. Each cycle it picks one eligible FIFO head, pops it, and holds the packet in a one-entry output register until the downstream consumer pops it. It sits between the per-direction input FIFOs and the outgoing link of a `mesh_gnrtr` node. It uses the same pending/pop handshake on both sides.

---
 rtl/mesh_out_arbiter_pkg.sv | 9 +
 rtl/mesh_out_arbiter_if.sv | 23 ++
 rtl/mesh_out_arbiter_rr_pick.sv | 23 ++
 rtl/mesh_out_arbiter.sv | 45 ++++
 tb/tb_mesh_out_arbiter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mesh_out_arbiter_pkg.sv
// mesh_arb_pkg: arbiter state type and packet field positions shared with the route decoder
package mesh_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int PCKG_SZ = 40;
  localparam int NXTJP_MSB = PCKG_SZ - 1;
  localparam int ROW_MSB = PCKG_SZ - 9;
  localparam int COL_MSB = PCKG_SZ - 13;
  localparam int MODE_BIT = PCKG_SZ - 17;
endpackage

// File: rtl/mesh_out_arbiter_if.sv
// mesh_out_arbiter_if: input-FIFO heads, pop strobes and outgoing-link handshake of one output port
interface mesh_out_arbiter_if #(
  parameter int N_IN = 4,
  parameter int pckg_sz = 40,
  parameter int CNT_W = 16
);
  logic [N_IN-1:0] pndng_i_in;
  logic [N_IN-1:0] route_hit;
  logic [N_IN*pckg_sz-1:0] data_out_i_in;
  logic [N_IN-1:0] popin;
  logic pndng;
  logic [pckg_sz-1:0] data_out;
  logic pop;
  logic [CNT_W-1:0] grant_cnt;
  modport master (
    input pndng_i_in, route_hit, data_out_i_in, pop,
    output popin, pndng, data_out, grant_cnt
  );
  modport slave (
    output pndng_i_in, route_hit, data_out_i_in, pop,
    input popin, pndng, data_out, grant_cnt
  );
endinterface

// File: rtl/mesh_out_arbiter_rr_pick.sv
// rr_pick: rotate requests by ptr, take the lowest set bit, rotate the index back
module rr_pick #(
  parameter int N_IN = 4,
  localparam int IW = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);
  localparam int SW = IW + 1;
  logic [N_IN-1:0] rot;
  logic [IW-1:0] off;
  logic [SW-1:0] sum;
  always_comb begin
    rot = N_IN'({req, req} >> ptr);
    off = '0;
    for (int k = N_IN - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_idx = (sum >= SW'(N_IN)) ? IW'(sum - SW'(N_IN)) : IW'(sum);
  end
  assign any = |req;
endmodule

// File: rtl/mesh_out_arbiter.sv
// mesh_out_arbiter: round-robin grant of eligible FIFO heads into a one-entry output register
module mesh_out_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int pckg_sz = 40,
  parameter int CNT_W = 16,
  localparam int IW = $clog2(N_IN)
) (
  input logic clk,
  input logic reset,
  mesh_out_arbiter_if.master bus
);
  arb_state_e state;
  logic [IW-1:0] ptr, w;
  logic [N_IN-1:0] elig;
  logic any, free;
  logic [pckg_sz-1:0] din;
  assign elig = bus.pndng_i_in & bus.route_hit;
  assign free = !bus.pndng | bus.pop;
  assign din = pckg_sz'(bus.data_out_i_in >> (w * pckg_sz));
  rr_pick #(.N_IN(N_IN)) u_pick (.req(elig), .ptr(ptr), .gnt_idx(w), .any(any));
  // GRANT is a dead cycle: the popped FIFO's pending flag is still stale
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      bus.popin <= '0;
      bus.pndng <= 1'b0;
      bus.data_out <= '0;
      bus.grant_cnt <= '0;
    end else if (state == IDLE && any && free) begin
      state <= GRANT;
      ptr <= (w == IW'(N_IN - 1)) ? '0 : w + IW'(1);
      bus.popin <= N_IN'(1) << w;
      bus.pndng <= 1'b1;
      bus.data_out <= din;
      bus.grant_cnt <= &bus.grant_cnt ? bus.grant_cnt : bus.grant_cnt + CNT_W'(1);
    end else begin
      state <= IDLE;
      bus.popin <= '0;
      if (bus.pop) bus.pndng <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mesh_out_arbiter.sv
// tb_mesh_out_arbiter: per-cycle compare against a queue-free arbitration model plus directed literal checks
module tb_mesh_out_arbiter;
  localparam int N = 4;
  localparam int PW = 40;
  localparam int CW = 4;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  mesh_out_arbiter_if #(.N_IN(N), .pckg_sz(PW), .CNT_W(CW)) bus ();
  mesh_out_arbiter #(.N_IN(N), .pckg_sz(PW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  int glog[$];
  bit m_busy = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int w;
  int idx;
  logic [N-1:0] m_popin = '0;
  logic m_pndng = 0;
  logic [PW-1:0] m_data = '0;
  logic [N-1:0] el;
  function automatic logic [PW-1:0] dval(input int i);
    return {8'hA5, 4'h0, 4'(i), 4'h1, 20'h00001};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [N-1:0] pnd, input logic [N-1:0] hit, input logic p);
    bus.pndng_i_in = pnd;
    bus.route_hit = hit;
    bus.pop = p;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1;
    drive('0, '0, 0);
    @(negedge clk);
    reset = 0;
    glog.delete();
  endtask
  // model: first eligible input searching upward from ptr, at most one grant per two cycles
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_ptr <= 0; m_cnt <= 0; m_popin <= '0; m_pndng <= 0; m_data <= '0;
    end else begin
      w = -1;
      el = bus.pndng_i_in & bus.route_hit;
      if (!m_busy && (!m_pndng || bus.pop))
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && el[idx[1:0]]) w = idx;
        end
      if (w >= 0) begin
        m_busy <= 1;
        m_ptr <= (w + 1) % N;
        m_popin <= N'(1 << w);
        m_pndng <= 1;
        m_data <= PW'(bus.data_out_i_in >> (w * PW));
        m_cnt <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      end else begin
        m_busy <= 0;
        m_popin <= '0;
        if (bus.pop) m_pndng <= 0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("popin", 64'(bus.popin), 64'(m_popin));
      chk("pndng", 64'(bus.pndng), 64'(m_pndng));
      chk("data_out", 64'(bus.data_out), 64'(m_data));
      chk("grant_cnt", 64'(bus.grant_cnt), 64'(m_cnt));
      for (int k = 0; k < N; k++) if (bus.popin[k]) glog.push_back(k);
    end
  end
  initial begin
    drive('0, '0, 0);
    bus.data_out_i_in = {dval(3), dval(2), dval(1), dval(0)};
    tick(2);
    chk_en = 1;
    chk("rst_popin", 64'(bus.popin), 64'h0);
    chk("rst_pndng", 64'(bus.pndng), 64'h0);
    chk("rst_data", 64'(bus.data_out), 64'h0);
    chk("rst_cnt", 64'(bus.grant_cnt), 64'h0);
    reset = 0;
    drive(4'b0100, 4'hF, 0);
    tick(1);
    chk("single_popin", 64'(bus.popin), 64'b0100);
    chk("single_pndng", 64'(bus.pndng), 64'h1);
    chk("single_data", 64'(bus.data_out), 64'hA5_0_2_1_00001);
    chk("single_cnt", 64'(bus.grant_cnt), 64'h1);
    drive('0, 4'hF, 0);
    tick(5);
    chk("single_no_more", 64'(bus.popin), 64'h0);
    chk("single_cnt_hold", 64'(bus.grant_cnt), 64'h1);
    chk("single_glog", 64'(glog.size()), 64'd1);
    do_reset();
    drive(4'hF, 4'hF, 1);
    tick(16);
    chk("fair_cnt", 64'(bus.grant_cnt), 64'd8);
    chk("fair_glog", 64'(glog.size()), 64'd8);
    for (int k = 0; k < glog.size(); k++) chk("fair_order", 64'(glog[k]), 64'(k % 4));
    do_reset();
    drive(4'b0011, 4'hF, 0);
    tick(1);
    chk("bp_first", 64'(bus.popin), 64'b0001);
    drive(4'b0010, 4'hF, 0);
    tick(10);
    chk("bp_stall_glog", 64'(glog.size()), 64'd1);
    chk("bp_stall_data", 64'(bus.data_out), 64'(dval(0)));
    drive(4'b0010, 4'hF, 1);
    tick(1);
    chk("bp_second", 64'(bus.popin), 64'b0010);
    chk("bp_pndng", 64'(bus.pndng), 64'h1);
    chk("bp_swap", 64'(bus.data_out), 64'(dval(1)));
    drive('0, 4'hF, 0);
    tick(2);
    do_reset();
    drive(4'b0100, 4'hF, 1);
    tick(1);
    chk("wrap_pre", 64'(bus.popin), 64'b0100);
    drive('0, 4'hF, 1);
    tick(1);
    drive(4'b1001, 4'b0001, 1);
    tick(1);
    chk("wrap_filter", 64'(bus.popin), 64'b0001);
    drive(4'hF, 4'hF, 1);
    tick(2);
    chk("wrap_ptr1", 64'(bus.popin), 64'b0010);
    do_reset();
    drive(4'b0001, 4'hF, 0);
    tick(1);
    chk("rg_grant", 64'(bus.popin), 64'b0001);
    reset = 1;
    tick(1);
    chk("rg_popin", 64'(bus.popin), 64'h0);
    chk("rg_pndng", 64'(bus.pndng), 64'h0);
    chk("rg_data", 64'(bus.data_out), 64'h0);
    chk("rg_cnt", 64'(bus.grant_cnt), 64'h0);
    reset = 0;
    tick(1);
    chk("rg_resume", 64'(bus.popin), 64'b0001);
    chk("rg_resume_cnt", 64'(bus.grant_cnt), 64'h1);
    do_reset();
    drive(4'hF, 4'hF, 1);
    tick(28);
    chk("sat_14", 64'(bus.grant_cnt), 64'hE);
    tick(12);
    chk("sat_hold", 64'(bus.grant_cnt), 64'hF);
    drive('0, '0, 0);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
